mux2_32: RTL and testbench
==========================

Name: mux2_32

Overview:
- 2:1 word multiplexer for the MIPS datapath: selects one of two WIDTH-bit operands, default 32, by a single select bit.
- Typical uses: PC-source, ALU-source and write-back select.
- The primary output y is purely combinational.
- A registered copy y_q is also provided for pipelined users. It runs on clk and clears on the synchronous active-low rst.

Parameters:
- WIDTH, 32, data width of d0, d1, y and y_q in bits.
- RESET_VAL, '0, value loaded into y_q while rst is low.

Ports:
- clk  input  1  clock; only y_q and s_q are sampled on its rising edge.
- rst  input  1  reset, synchronous, active-low; clock clk.
- d0  input  WIDTH  data operand selected when s = 0.
- d1  input  WIDTH  data operand selected when s = 1.
- s  input  1  select; 0 picks d0, 1 picks d1.
- y  output  WIDTH  combinational result.
- y_q  output  WIDTH  result of y registered on the rising edge of clk.
- s_q  output  1  s registered alongside y_q, for downstream alignment and debug.

Behaviour:
- y = d1 when s = 1; y = d0 when s = 0. Zero latency.
- y is a pure function of d0, d1 and s. It is independent of clk and rst, including during reset.
- y must settle within the same evaluation as an input change. A bench sampling 5 ns after applying inputs sees the final value.
- If s is X/Z in simulation:
  - bits where d0 and d1 agree take that value;
  - bits where they differ are X.
  - This matches conditional-operator semantics; no silent default to d0.
- No arithmetic, no width conversion. d0, d1 and y are all exactly WIDTH bits with no sign or zero extension.
- On a rising clk edge with rst = 0: y_q <= RESET_VAL and s_q <= 0.
- On a rising clk edge with rst = 1: y_q <= y and s_q <= s. Latency from y to y_q is one cycle.
- Reset asserted mid-operation: y_q and s_q clear on the first rising edge with rst low. They hold that value while rst stays low.
- Reset release: the first edge with rst high captures the then-current y.
- Before the first rising edge, y_q and s_q are undefined. Users must apply reset for at least one cycle.
- Inputs changing exactly at the clock edge: normal setup/hold rules apply. y_q captures the pre-edge value of y.
- No handshake and no state machine.
- Bit-exact: y must be compared with case equality (===) in verification. Any X on y for known s, d0, d1 is a failure.

Decomposition:
- Shared package mips_pkg: WIDTH default constant (DATA_W = 32) and typedef word_t = logic [DATA_W-1:0], reused by the other datapath muxes.
- Sub-module: one generic register, dff_rst_n (parameterized width, synchronous active-low reset, reset value), used for both y_q and s_q.
- The mux itself stays a single continuous assignment in mux2_32.

Test Plan:
- Select d0: d0=32'h0000_00FF, d1=32'hFFFF_0000, s=0 -> y=32'h0000_00FF. Next edge, rst=1 -> y_q=32'h0000_00FF, s_q=0.
- Select d1: d0=32'h1234_5678, d1=32'h8765_4321, s=1 -> y=32'h8765_4321. Next edge, rst=1 -> y_q=32'h8765_4321, s_q=1.
- Extremes:
  - d0=32'h0000_0000, d1=32'hFFFF_FFFF, s=1 -> y=32'hFFFF_FFFF.
  - Then s=0 -> y=32'h0000_0000.
  - Also d0=d1=32'hAAAA_5555, either s -> y=32'hAAAA_5555.
- Reset:
  - Hold rst=0 for 2 edges with s=1, d1=32'hDEAD_BEEF -> y=32'hDEAD_BEEF immediately, y_q=0, s_q=0.
  - Release rst -> y_q=32'hDEAD_BEEF one edge later.
- Mid-stream reset and toggling:
  - Alternate s every cycle for 4 cycles with d0=32'h1, d1=32'h2 -> y_q sequence follows y delayed by one cycle.
  - Drop rst for one edge -> y_q=0 that cycle, then resumes tracking.
- X-select: s=1'bx, d0=32'hF0F0_0000, d1=32'hF0F0_FFFF -> y[31:16]=16'hF0F0, y[15:0] all X.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS datapath muxes.
//   DATA_W : default datapath word width in bits
//   word_t : one datapath word
package mips_pkg;

  localparam int DATA_W = 32;

  typedef logic [DATA_W-1:0] word_t;

endpackage : mips_pkg

// File: rtl/dff_rst_n.sv
// Generic register with synchronous, active-low reset.
// Ports:
//   clk_i  : clock, rising edge
//   rst_ni : synchronous reset, active low; loads RST_VAL
//   d_i    : data in
//   q_o    : registered data out
module dff_rst_n #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  always_comb begin
    data_d = d_i;
    if (!rst_ni) begin
      data_d = RST_VAL;
    end
  end

  always_ff @(posedge clk_i) begin
    data_q <= data_d;
  end

  assign q_o = data_q;

endmodule : dff_rst_n

// File: rtl/mux2_32.sv
// 2:1 word multiplexer for the MIPS datapath (PC-source, ALU-source,
// write-back select), with a registered copy for pipelined consumers.
// Ports:
//   clk : clock; only y_q and s_q are sampled on its rising edge
//   rst : synchronous reset, active low
//   d0  : operand selected when s = 0
//   d1  : operand selected when s = 1
//   s   : select
//   y   : combinational result, independent of clk/rst
//   y_q : y registered one cycle later (RESET_VAL under reset)
//   s_q : s registered alongside y_q (0 under reset)
module mux2_32
  import mips_pkg::*;
#(
  parameter int               WIDTH     = DATA_W,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic             s,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             s_q
);

  // Conditional operator keeps X-select pessimism honest in simulation:
  // bits where d0 and d1 agree survive, the rest go X.
  assign y = s ? d1 : d0;

  dff_rst_n #(
    .W       (WIDTH),
    .RST_VAL (RESET_VAL)
  ) u_y_reg (
    .clk_i  (clk),
    .rst_ni (rst),
    .d_i    (y),
    .q_o    (y_q)
  );

  dff_rst_n #(
    .W       (1),
    .RST_VAL (1'b0)
  ) u_s_reg (
    .clk_i  (clk),
    .rst_ni (rst),
    .d_i    (s),
    .q_o    (s_q)
  );

endmodule : mux2_32

// File: tb/tb_mux2_32.sv
// Self-checking bench for mux2_32: directed cases plus randomized traffic
// compared against a word-select reference model and a one-deep register model.
module tb_mux2_32;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] d0;
  logic [31:0] d1;
  logic        s;
  logic [31:0] y;
  logic [31:0] y_q;
  logic        s_q;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_yq;
  logic        exp_sq;

  mux2_32 dut (
    .clk (clk),
    .rst (rst),
    .d0  (d0),
    .d1  (d1),
    .s   (s),
    .y   (y),
    .y_q (y_q),
    .s_q (s_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Reference: pick operand number sel out of the pair.
  function automatic logic [31:0] pick(input logic sel, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ops [2];
    ops[0] = a;
    ops[1] = b;
    return ops[int'(sel)];
  endfunction

  // Drive one cycle's inputs after the falling edge, check y before the
  // rising edge, then check the registered outputs just after it.
  task automatic step(input string tag, input logic r, input logic sel,
                      input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ref_y;
    @(negedge clk);
    rst = r;
    s   = sel;
    d0  = a;
    d1  = b;
    ref_y = pick(sel, a, b);
    #4;
    check({tag, "_y"}, y, ref_y);
    @(posedge clk);
    if (r) begin
      exp_yq = ref_y;
      exp_sq = sel;
    end else begin
      exp_yq = 32'h0;
      exp_sq = 1'b0;
    end
    #1;
    check({tag, "_yq"}, y_q, exp_yq);
    check({tag, "_sq"}, {31'b0, s_q}, {31'b0, exp_sq});
  endtask

  initial begin
    rst = 1'b0;
    s   = 1'b0;
    d0  = '0;
    d1  = '0;

    // Reset state
    step("rst0", 1'b0, 1'b0, 32'h0000_1111, 32'h2222_0000);

    // Select d0 / d1
    step("sel_d0", 1'b1, 1'b0, 32'h0000_00FF, 32'hFFFF_0000);
    step("sel_d1", 1'b1, 1'b1, 32'h1234_5678, 32'h8765_4321);

    // Extremes and equal operands
    step("ext_ones",  1'b1, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF);
    step("ext_zeros", 1'b1, 1'b0, 32'h0000_0000, 32'hFFFF_FFFF);
    step("eq_s0",     1'b1, 1'b0, 32'hAAAA_5555, 32'hAAAA_5555);
    step("eq_s1",     1'b1, 1'b1, 32'hAAAA_5555, 32'hAAAA_5555);

    // Reset held two edges: y stays live, registers cleared
    step("rst_hold0", 1'b0, 1'b1, 32'h0000_0000, 32'hDEAD_BEEF);
    step("rst_hold1", 1'b0, 1'b1, 32'h0000_0000, 32'hDEAD_BEEF);
    step("rst_rel",   1'b1, 1'b1, 32'h0000_0000, 32'hDEAD_BEEF);

    // Toggle select, one-edge reset mid-stream, then resume tracking
    for (int i = 0; i < 4; i++) step("toggle", 1'b1, i[0], 32'h1, 32'h2);
    step("mid_rst", 1'b0, 1'b0, 32'h1, 32'h2);
    step("resume0", 1'b1, 1'b1, 32'h1, 32'h2);
    step("resume1", 1'b1, 1'b0, 32'h1, 32'h2);

    // X select: agreeing bits keep their value, differing bits go X
    @(negedge clk);
    rst = 1'b1;
    d0  = 32'hF0F0_0000;
    d1  = 32'hF0F0_FFFF;
    s   = 1'bx;
    #2;
    check("xsel_hi", {16'h0, y[31:16]}, 32'h0000_F0F0);
    if ($isunknown(s)) check("xsel_lo", {16'h0, y[15:0]}, {16'h0, 16'hxxxx});
    s = 1'b0;
    #1;
    check("xsel_fix", y, 32'hF0F0_0000);
    @(posedge clk);
    #1;
    check("xsel_yq", y_q, 32'hF0F0_0000);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 200; i++) begin
      step("rand", ($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)), $urandom, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_mux2_32
